// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the instruction-fetch path. The PC advances
// on an automatic prescaler tick or on a manual single-step edge. The mode
// input selects increment, decrement, hold, absolute load, call, return or
// relative branch. A small LIFO holds return addresses, and sticky flags
// report a call into a full stack or a return from an empty one.
//
// Parameters
//   WIDTH       PC / data width in bits
//   TICK_DIV    clock cycles per automatic advance tick (>= 1)
//   STACK_DEPTH number of return-address entries (>= 1)
//   RESET_VEC   PC value loaded on reset
//
// Ports
//   clk          system clock, rising edge
//   pc_clr       asynchronous active-high reset
//   M            mode select (INC, DEC, HOLD, LOAD, CALL, RET, BRANCH, rsvd)
//   DATA_INPUT   absolute load / call target
//   OFFSET       two's-complement relative branch offset
//   manual_step  single-step request (level); its rising edge acts as a tick
//   err_clr      clears the sticky error flags
//   PC           current program counter
//   tick         one-cycle pulse while the prescaler sits at its last count
//   sp           stack occupancy
//   stack_full   sp == STACK_DEPTH
//   stack_empty  sp == 0
//   ovf_err      sticky: call attempted while the stack was full
//   unf_err      sticky: return attempted while the stack was empty
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0
) (
    input  logic                               clk,
    input  logic                               pc_clr,
    input  logic [2:0]                         M,
    input  logic [WIDTH-1:0]                   DATA_INPUT,
    input  logic [WIDTH-1:0]                   OFFSET,
    input  logic                               manual_step,
    input  logic                               err_clr,
    output logic [WIDTH-1:0]                   PC,
    output logic                               tick,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        MODE_INC    = 3'b000,
        MODE_DEC    = 3'b001,
        MODE_HOLD   = 3'b010,
        MODE_LOAD   = 3'b011,
        MODE_CALL   = 3'b100,
        MODE_RET    = 3'b101,
        MODE_BRANCH = 3'b110,
        MODE_RSVD   = 3'b111
    } mode_e;

    // -------------------------------------------------------------------------
    // Registered state and its next-state values
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q,  pc_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [SP_W-1:0]  sp_q,  sp_next;
    logic             step_prev_q;
    logic             ovf_q, ovf_next;
    logic             unf_q, unf_next;

    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    mode_e            mode;
    logic             step_pulse;
    logic             adv;
    logic             full;
    logic             empty;
    logic             push_en;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [WIDTH-1:0] pc_plus1;

    assign mode = mode_e'(M);

    // Prescaler wrap is decoded from the registered count, so tick is a clean
    // function of state and needs no extra flop. With TICK_DIV = 1 the count
    // never leaves 0 and tick stays high.
    assign tick = (cnt_q == CNT_MAX);

    // Only the rising edge of the step level counts; holding the button does
    // not keep advancing. OR-ing with tick collapses a coincident tick and
    // step into a single advance.
    assign step_pulse = manual_step & ~step_prev_q;
    assign adv        = tick | step_pulse;

    assign full  = (sp_q == SP_MAX);
    assign empty = (sp_q == '0);

    // sp never exceeds STACK_DEPTH, so its low bits address the array
    // directly; a push only happens when sp < STACK_DEPTH and a pop only when
    // sp >= 1, which keeps both indices inside the array.
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = push_idx - IDX_W'(1);
    assign pc_plus1 = pc_q + WIDTH'(1);

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        pc_next  = pc_q;
        sp_next  = sp_q;
        cnt_next = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        push_en  = 1'b0;
        ovf_next = ovf_q & ~err_clr;
        unf_next = unf_q & ~err_clr;

        if (mode == MODE_LOAD) begin
            // Load is level-sensitive and ignores the advance qualifier.
            pc_next = DATA_INPUT;
        end else if (adv) begin
            unique case (mode)
                MODE_INC:    pc_next = pc_plus1;
                MODE_DEC:    pc_next = pc_q - WIDTH'(1);
                MODE_BRANCH: pc_next = pc_q + OFFSET;
                MODE_CALL: begin
                    if (!full) begin
                        push_en = 1'b1;
                        sp_next = sp_q + SP_W'(1);
                        pc_next = DATA_INPUT;
                    end else begin
                        // A new error outranks a simultaneous clear.
                        ovf_next = 1'b1;
                    end
                end
                MODE_RET: begin
                    if (!empty) begin
                        sp_next = sp_q - SP_W'(1);
                        pc_next = stack_mem[pop_idx];
                    end else begin
                        unf_next = 1'b1;
                    end
                end
                MODE_HOLD, MODE_LOAD, MODE_RSVD: pc_next = pc_q;
                default:     pc_next = pc_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge pc_clr) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (pc_clr) begin
            pc_q        <= RST_PC;
            cnt_q       <= '0;
            sp_q        <= '0;
            step_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            cnt_q       <= cnt_next;
            sp_q        <= sp_next;
            step_prev_q <= manual_step;
            ovf_q       <= ovf_next;
            unf_q       <= unf_next;
        end
    end

    // NOTE: the return-address array has no reset; entries above sp are never
    // read, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PC          = pc_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer (WIDTH=8, TICK_DIV=4, STACK_DEPTH=2,
// RESET_VEC=8'hFF). The stimulus process drives inputs just after a rising
// edge and queues the hand-computed values the outputs must show; a monitor
// on the falling edge pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int SEL_PC    = 0;
    localparam int SEL_TICK  = 1;
    localparam int SEL_SP    = 2;
    localparam int SEL_FULL  = 3;
    localparam int SEL_EMPTY = 4;
    localparam int SEL_OVF   = 5;
    localparam int SEL_UNF   = 6;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       pc_clr;
    logic [2:0] M;
    logic [7:0] DATA_INPUT;
    logic [7:0] OFFSET;
    logic       manual_step;
    logic       err_clr;
    logic [7:0] PC;
    logic       tick;
    logic [1:0] sp;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pre    = 0;   // bench model of the prescaler count

    pc_sequencer #(
        .WIDTH      (8),
        .TICK_DIV   (4),
        .STACK_DEPTH(2),
        .RESET_VEC  (255)
    ) dut (
        .clk        (clk),
        .pc_clr     (pc_clr),
        .M          (M),
        .DATA_INPUT (DATA_INPUT),
        .OFFSET     (OFFSET),
        .manual_step(manual_step),
        .err_clr    (err_clr),
        .PC         (PC),
        .tick       (tick),
        .sp         (sp),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_PC:    return PC;
            SEL_TICK:  return {7'd0, tick};
            SEL_SP:    return {6'd0, sp};
            SEL_FULL:  return {7'd0, stack_full};
            SEL_EMPTY: return {7'd0, stack_empty};
            SEL_OVF:   return {7'd0, ovf_err};
            SEL_UNF:   return {7'd0, unf_err};
            default:   return 8'hxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, observe(e.sel), e.val);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic exp_push(input string name, input int sel, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        pre = (pre == 3) ? 0 : pre + 1;
    endtask

    // Leaves the bench just before the edge on which tick is high.
    task automatic to_tick_edge();
        while (pre != 3) clk_step();
    endtask

    task automatic exp_stack(input string tag, input logic [7:0] s,
                             input logic f, input logic em);
        exp_push({tag, "_sp"},    SEL_SP,    s);
        exp_push({tag, "_full"},  SEL_FULL,  {7'd0, f});
        exp_push({tag, "_empty"}, SEL_EMPTY, {7'd0, em});
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        pc_clr      = 1'b1;
        M           = 3'b000;
        DATA_INPUT  = 8'h00;
        OFFSET      = 8'h00;
        manual_step = 1'b0;
        err_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pc_clr = 1'b0;
        pre    = 0;

        // Reset state
        exp_push("rst_pc",   SEL_PC,   8'hFF);
        exp_push("rst_tick", SEL_TICK, 8'h00);
        exp_stack("rst", 8'd0, 1'b0, 1'b1);
        exp_push("rst_ovf",  SEL_OVF,  8'h00);
        exp_push("rst_unf",  SEL_UNF,  8'h00);

        // 1. INC for 12 cycles: advance on every 4th edge, tick one cycle ahead
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            exp_push($sformatf("inc_pc_%0d", k),   SEL_PC,   8'hFF + 8'(k / 4));
            exp_push($sformatf("inc_tick_%0d", k), SEL_TICK, {7'd0, (k % 4) == 3});
        end

        // 2. DEC wraps 00 -> FF; LOAD acts without a tick
        M = 3'b011; DATA_INPUT = 8'h00;
        clk_step();
        exp_push("load00", SEL_PC, 8'h00);
        M = 3'b001;
        to_tick_edge();
        exp_push("dec_wait", SEL_PC, 8'h00);
        clk_step();
        exp_push("dec_wrap", SEL_PC, 8'hFF);
        M = 3'b011; DATA_INPUT = 8'h3C;
        clk_step();
        exp_push("load3c",      SEL_PC,   8'h3C);
        exp_push("load3c_tick", SEL_TICK, 8'h00);

        // 3. Step level in HOLD, then step coincident with tick in INC
        M = 3'b010; manual_step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            exp_push($sformatf("hold_step_%0d", k), SEL_PC, 8'h3C);
        end
        manual_step = 1'b0;
        clk_step();
        to_tick_edge();
        M = 3'b000; manual_step = 1'b1;
        clk_step();
        exp_push("step_tick_once", SEL_PC, 8'h3D);
        for (int k = 0; k < 3; k++) begin
            clk_step();
            exp_push($sformatf("step_level_%0d", k), SEL_PC, 8'h3D);
        end
        clk_step();
        exp_push("tick_level_high", SEL_PC, 8'h3E);
        manual_step = 1'b0;
        clk_step();
        exp_push("step_release", SEL_PC, 8'h3E);
        manual_step = 1'b1;
        clk_step();
        exp_push("step_alone", SEL_PC, 8'h3F);
        manual_step = 1'b0;

        // 4. Two calls fill the stack, third overflows; two returns unwind
        M = 3'b011; DATA_INPUT = 8'h10;
        clk_step();
        exp_push("load10", SEL_PC, 8'h10);
        M = 3'b100; DATA_INPUT = 8'h40;
        to_tick_edge(); clk_step();
        exp_push("call40", SEL_PC, 8'h40);
        exp_stack("call40", 8'd1, 1'b0, 1'b0);
        DATA_INPUT = 8'h80;
        to_tick_edge(); clk_step();
        exp_push("call80", SEL_PC, 8'h80);
        exp_stack("call80", 8'd2, 1'b1, 1'b0);
        exp_push("call80_ovf", SEL_OVF, 8'h00);
        DATA_INPUT = 8'hC0;
        to_tick_edge(); clk_step();
        exp_push("call_ovf_pc", SEL_PC,  8'h80);
        exp_stack("call_ovf", 8'd2, 1'b1, 1'b0);
        exp_push("call_ovf",    SEL_OVF, 8'h01);
        M = 3'b101;
        to_tick_edge(); clk_step();
        exp_push("ret1", SEL_PC, 8'h41);
        exp_stack("ret1", 8'd1, 1'b0, 1'b0);
        to_tick_edge(); clk_step();
        exp_push("ret2", SEL_PC, 8'h11);
        exp_stack("ret2", 8'd0, 1'b0, 1'b1);
        exp_push("ret2_ovf_sticky", SEL_OVF, 8'h01);

        // 5. Underflow, clear, then clear coincident with a new underflow
        to_tick_edge(); clk_step();
        exp_push("unf_pc",  SEL_PC,  8'h11);
        exp_push("unf_set", SEL_UNF, 8'h01);
        exp_push("unf_sp",  SEL_SP,  8'h00);
        M = 3'b010; err_clr = 1'b1;
        clk_step();
        exp_push("clr_unf", SEL_UNF, 8'h00);
        exp_push("clr_ovf", SEL_OVF, 8'h00);
        M = 3'b101;
        to_tick_edge(); clk_step();
        exp_push("unf_set_wins", SEL_UNF, 8'h01);
        exp_push("unf_set_pc",   SEL_PC,  8'h11);
        err_clr = 1'b0; M = 3'b010;
        clk_step();
        exp_push("unf_sticky", SEL_UNF, 8'h01);

        // 6. Negative branch, reserved mode, then reset in the middle of a call
        M = 3'b011; DATA_INPUT = 8'h05;
        clk_step();
        exp_push("load05", SEL_PC, 8'h05);
        M = 3'b110; OFFSET = 8'hFA;
        to_tick_edge(); clk_step();
        exp_push("branch_neg", SEL_PC, 8'hFF);
        M = 3'b111;
        to_tick_edge(); clk_step();
        exp_push("reserved_hold", SEL_PC, 8'hFF);
        M = 3'b100; DATA_INPUT = 8'h20;
        to_tick_edge(); clk_step();
        exp_push("call20", SEL_PC, 8'h20);
        exp_push("call20_sp", SEL_SP, 8'h01);
        DATA_INPUT = 8'h30;
        to_tick_edge();
        #1;
        pc_clr = 1'b1;
        exp_push("async_pc",  SEL_PC,  8'hFF);
        exp_stack("async", 8'd0, 1'b0, 1'b1);
        exp_push("async_ovf", SEL_OVF, 8'h00);
        exp_push("async_unf", SEL_UNF, 8'h00);
        @(posedge clk);
        #1;
        exp_push("rst_discard_pc", SEL_PC, 8'hFF);
        pc_clr = 1'b0;
        pre    = 0;
        M      = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            exp_push($sformatf("post_rst_pc_%0d", k), SEL_PC, (k == 4) ? 8'h00 : 8'hFF);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
